// File: rtl/lsu_ctrl_pkg.sv
// Shared constants and helpers for the load/store unit: access-size codes,
// FSM state encoding, fault cause codes and legality/alignment checks.
package lsu_ctrl_pkg;

  // funct3 access-size / sign codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // Fault cause codes
  localparam logic [1:0] LSU_FC_MISAL = 2'd0;
  localparam logic [1:0] LSU_FC_ILL   = 2'd1;
  localparam logic [1:0] LSU_FC_TMO   = 2'd2;

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W);
    if (!is_store) begin
      ok = ok || (f3 == LSU_BU) || (f3 == LSU_HU);
    end
    return ok;
  endfunction

  // Size lives in funct3[1:0]: 01 = half, 10 = word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane enables for the addressed bytes within the word.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it according to funct3. Word loads pass through unchanged.
module lsu_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  data = {24'h000000, byte_sel};
      LSU_H:   data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns an ALU effective address plus load/store
// control into one data-memory transaction, stalls the core while it is
// outstanding and reports misaligned, illegal or timed-out accesses.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  // Last BUSY cycle before giving up on the memory
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             req_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [3:0]       be_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      load_reg;
  logic [1:0]       off_reg;
  logic [2:0]       f3_reg;

  logic             access;
  logic             is_store;
  logic             legal;
  logic             misal;
  logic             start;
  logic             idle_fault;
  logic             tmo_hit;
  logic [31:0]      wdata_next;
  logic [31:0]      aligned_data;

  // A store wins when both strobes are set, so mem_write alone decides direction.
  assign access     = mem_read | mem_write;
  assign is_store   = mem_write;
  assign legal      = f3_legal(is_store, funct3);
  assign misal      = f3_misaligned(funct3, alu_result[1:0]);
  assign start      = (state_reg == LSU_IDLE) && access && legal && !misal;
  assign idle_fault = (state_reg == LSU_IDLE) && access && !(legal && !misal);
  assign tmo_hit    = (state_reg == LSU_BUSY) && !dmem_ready && (cnt_reg == TMO_LAST);

  // The stall must cover the accepting IDLE cycle, so it is combinational.
  assign lsu_stall    = start || ((state_reg == LSU_BUSY) && !tmo_hit);
  assign access_fault = idle_fault || tmo_hit;

  // Fault cause; illegal funct3 takes priority over misalignment
  always_comb begin
    fault_cause = LSU_FC_MISAL;
    if (tmo_hit) begin
      fault_cause = LSU_FC_TMO;
    end else if (idle_fault && !legal) begin
      fault_cause = LSU_FC_ILL;
    end
  end

  // Store data replicated onto every lane so the byte enables pick the right one
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_next[8*gi +: 8] =
        !is_store               ? 8'h00 :
        (funct3[1:0] == 2'b00)  ? store_data[7:0] :
        (funct3[1:0] == 2'b01)  ? store_data[8*(gi%2) +: 8] :
                                  store_data[8*gi +: 8];
  end

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .offset (off_reg),
    .funct3 (f3_reg),
    .data   (aligned_data)
  );

  // Controller FSM with registered memory-side outputs and load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LSU_IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      load_reg  <= '0;
      off_reg   <= '0;
      f3_reg    <= '0;
    end else begin
      case (state_reg)
        LSU_IDLE: begin
          if (start) begin
            addr_reg  <= {alu_result[31:2], 2'b00};
            be_reg    <= be_gen(funct3, alu_result[1:0]);
            wdata_reg <= wdata_next;
            we_reg    <= is_store;
            off_reg   <= alu_result[1:0];
            f3_reg    <= funct3;
            req_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (dmem_ready) begin
            if (!we_reg) begin
              load_reg <= aligned_data;
            end
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= LSU_DONE;
          end else if (cnt_reg == TMO_LAST) begin
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= LSU_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LSU_DONE: begin
          state_reg <= LSU_IDLE;
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= LSU_IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign load_data  = load_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a scoreboard of expected memory requests
// and load results is filled as each access is driven and drained as the DUT
// presents its request and completes.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        lsu_stall;
  logic [31:0] load_data;
  logic        access_fault;
  logic [1:0]  fault_cause;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .lsu_stall    (lsu_stall),
    .load_data    (load_data),
    .access_fault (access_fault),
    .fault_cause  (fault_cause),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata)
  );

  // Global watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    alu_result = 32'h0;
    store_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data,
         access_fault, fault_cause, lsu_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h load=%h fault=%b cause=%0d stall=%b, required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data,
               access_fault, fault_cause, lsu_stall);
    end
    rst_n = 1'b1;
    @(posedge clk);
    $display("reset: done");
  endtask

  // One legal access: ready returned after 'delay' extra BUSY cycles
  task automatic run_access(input string name, input logic wr, input logic rd,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_load);
    exp_t e;
    exp_t got;
    int   waited;
    @(posedge clk); #1;
    mem_write  = wr;
    mem_read   = rd;
    funct3     = f3;
    alu_result = addr;
    store_data = sdata;
    e.addr = exp_addr; e.be = exp_be; e.we = wr; e.wdata = exp_wdata; e.load = exp_load;
    sb.push_back(e);
    @(negedge clk);
    n_checks++;
    if (lsu_stall !== 1'b1 || access_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_stall: stall=%b fault=%b, required stall=1 fault=0",
               name, lsu_stall, access_fault);
    end
    waited = 0;
    while (dmem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    got = sb.pop_front();
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== got.addr || dmem_be !== got.be ||
        dmem_we !== got.we || dmem_wdata !== got.wdata || lsu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s request: req=%b addr=%h be=%b we=%b wdata=%h stall=%b, required req=1 addr=%h be=%b we=%b wdata=%h stall=1",
               name, dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata, lsu_stall,
               got.addr, got.be, got.we, got.wdata);
    end
    repeat (delay) @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    #1;
    n_checks++;
    if (access_fault !== 1'b0 || lsu_stall !== 1'b1 || dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_cycle: fault=%b stall=%b req=%b, required fault=0 stall=1 req=1",
               name, access_fault, lsu_stall, dmem_req);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (lsu_stall !== 1'b0 || dmem_req !== 1'b0 || load_data !== got.load) begin
      n_fail++;
      $display("FAIL %s done: stall=%b req=%b load=%h, required stall=0 req=0 load=%h",
               name, lsu_stall, dmem_req, load_data, got.load);
    end
    $display("access %s: addr=%h be=%b we=%b wdata=%h load=%h", name,
             dmem_addr, dmem_be, dmem_we, dmem_wdata, load_data);
  endtask

  task automatic test_loads();
    run_access("LW_100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_access("LB_203", 1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80000000, 0,
               32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_access("LBU_203", 1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 32'h80000000, 0,
               32'h200, 4'b1000, 32'h0, 32'h00000080);
    run_access("LHU_202", 1'b0, 1'b1, 3'b101, 32'h202, 32'h0, 32'h80000000, 0,
               32'h200, 4'b1100, 32'h0, 32'h00008000);
    run_access("LH_202", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 32'h80000000, 2,
               32'h200, 4'b1100, 32'h0, 32'hFFFF8000);
    run_access("LB_001", 1'b0, 1'b1, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0,
               32'h000, 4'b0010, 32'h0, 32'h0000007F);
  endtask

  task automatic test_stores();
    // Stores leave the previous load result (0x7F) in place
    run_access("SB_101", 1'b1, 1'b1, 3'b000, 32'h101, 32'h123456AB, 32'hFFFFFFFF, 0,
               32'h100, 4'b0010, 32'hABABABAB, 32'h0000007F);
    run_access("SH_102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h123456AB, 32'hFFFFFFFF, 1,
               32'h100, 4'b1100, 32'h56AB56AB, 32'h0000007F);
    run_access("SW_104", 1'b1, 1'b0, 3'b010, 32'h104, 32'h12345678, 32'hFFFFFFFF, 0,
               32'h104, 4'b1111, 32'h12345678, 32'h0000007F);
  endtask

  task automatic run_fault(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_cause);
    @(posedge clk); #1;
    mem_write  = wr;
    mem_read   = ~wr;
    funct3     = f3;
    alu_result = addr;
    store_data = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++;
    if (access_fault !== 1'b1 || fault_cause !== exp_cause ||
        lsu_stall !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s fault: fault=%b cause=%0d stall=%b req=%b, required fault=1 cause=%0d stall=0 req=0",
               name, access_fault, fault_cause, lsu_stall, dmem_req, exp_cause);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (access_fault !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: fault=%b req=%b, required fault=0 req=0",
               name, access_fault, dmem_req);
    end
    $display("fault %s: cause=%0d", name, exp_cause);
  endtask

  task automatic test_faults();
    run_fault("LW_misal", 1'b0, 3'b010, 32'h102, 2'd0);
    run_fault("LH_misal", 1'b0, 3'b001, 32'h101, 2'd0);
    run_fault("L011_ill", 1'b0, 3'b011, 32'h100, 2'd1);
    run_fault("S100_ill", 1'b1, 3'b100, 32'h100, 2'd1);
    run_fault("ill_over_misal", 1'b0, 3'b011, 32'h103, 2'd1);
  endtask

  task automatic test_timeout();
    int   req_cycles = 0;
    logic fault_seen = 1'b0;
    logic [1:0] cause_seen = 2'd3;
    logic stall_seen = 1'b1;
    @(posedge clk); #1;
    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h300;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1) break;
      req_cycles++;
      if (access_fault === 1'b1) begin
        fault_seen = 1'b1;
        cause_seen = fault_cause;
        stall_seen = lsu_stall;
        clear_inputs();
      end
    end
    clear_inputs();
    n_checks++;
    if (req_cycles != 16) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: %0d, required 16", req_cycles);
    end
    n_checks++;
    if (fault_seen !== 1'b1 || cause_seen !== 2'd2 || stall_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fault: seen=%b cause=%0d stall=%b, required seen=1 cause=2 stall=0",
               fault_seen, cause_seen, stall_seen);
    end
    n_checks++;
    if (dmem_req !== 1'b0 || lsu_stall !== 1'b0 || access_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: req=%b stall=%b fault=%b, required all 0",
               dmem_req, lsu_stall, access_fault);
    end
    $display("timeout: req_cycles=%0d cause=%0d", req_cycles, cause_seen);
  endtask

  task automatic test_ready_at_expiry();
    // Ready in the 16th BUSY cycle races the timeout; the access must complete
    run_access("LW_expiry", 1'b0, 1'b1, 3'b010, 32'h308, 32'h0, 32'h0BADF00D, 15,
               32'h308, 4'b1111, 32'h0, 32'h0BADF00D);
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h400;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre: req=%b, required 1", dmem_req);
    end
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data,
         access_fault, fault_cause, lsu_stall} !== '0) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: req=%b we=%b addr=%h be=%b wdata=%h load=%h fault=%b cause=%0d stall=%b, required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data,
               access_fault, fault_cause, lsu_stall);
    end
    rst_n = 1'b1;
    $display("reset mid-busy: outputs cleared");
    run_access("LW_after_rst", 1'b0, 1'b1, 3'b010, 32'h404, 32'h0, 32'h5A5A5A5A, 0,
               32'h404, 4'b1111, 32'h0, 32'h5A5A5A5A);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_ready_at_expiry();
    test_reset_mid_busy();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address and runs one data-memory transaction per load/store instruction.
- Generates word-aligned address, byte enables and lane-shifted write data; returns sign/zero-extended load data to writeback.
- Holds the core via lsu_stall until memory responds; flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for dmem_ready before a timeout fault; must be >= 1.
- CNT_W, 5, width of the timeout counter; 2^CNT_W must be > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_result  in  32  effective address from ALU.
- store_data  in  32  rs2 value.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size/sign.
- lsu_stall  out  1  core must hold PC and all inputs.
- load_data  out  32  extended load result; valid in DONE.
- access_fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  0=misaligned, 1=illegal funct3, 2=timeout.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, bits[1:0]=0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read word; valid with dmem_ready.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, counter=0. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, access_fault, fault_cause, lsu_stall (stall is combinational and 0 in IDLE with no access). Reset mid-BUSY aborts the request; dmem_req drops the next cycle.
- Access = mem_read | mem_write. If both are high, the instruction is a store and mem_read is ignored.
- funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with a legal, aligned access:
  - lsu_stall=1 combinationally.
  - Register address {addr[31:2],2'b00}, dmem_be, dmem_wdata and dmem_we; register addr[1:0] and funct3 internally; go to BUSY.
- IDLE with a fault:
  - No request, lsu_stall=0.
  - access_fault=1 and fault_cause valid for that same cycle only (combinational); the core traps.
  - Priority: illegal funct3 over misaligned.
- Byte enables and write data:
  - SB: be=0001<<addr[1:0], wdata=replicate byte x4.
  - SH: be=0011<<addr[1:0], wdata=replicate half x2.
  - SW: be=1111, wdata=store_data.
  - Loads: be is computed the same way; dmem_wdata=0.
- BUSY:
  - dmem_req=1; lsu_stall=1; counter increments each cycle.
  - dmem_ready=1: capture the extended rdata into load_data, go to DONE, clear the counter.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: go to IDLE, drop dmem_req. In that transition cycle access_fault=1, cause=2 and lsu_stall=0.
  - dmem_ready on the same cycle as timeout expiry: ready wins.
- DONE:
  - dmem_req=0; lsu_stall=0 for exactly one cycle; load_data holds the value; the core advances at the end of this cycle.
  - Always returns to IDLE; inputs are ignored in this cycle.
  - Back-to-back accesses therefore start a new request at DONE+1.
- Load extraction:
  - LB/LBU: byte at addr[1:0].
  - LH/LHU: half at addr[1].
  - Sign-extend LB/LH, zero-extend LBU/LHU.
  - Stores leave load_data unchanged.
- Minimum access latency: IDLE→BUSY→DONE = 3 cycles including the completion cycle when ready is returned in the first BUSY cycle.
- Registered outputs hold their values outside BUSY, except dmem_req, which is 0.

Decomposition:
- Shared param.v: funct3 defines LSU_B/H/W/BU/HU, FSM state encodings LSU_IDLE/BUSY/DONE, and fault cause codes LSU_FC_MISAL/ILL/TMO.
- One combinational sub-module, lsu_load_align (rdata, offset, funct3 -> extended load_data); it is also reused by the bench model.

Test Plan:
- LW addr 0x100, ready in first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111; stall high 2 cycles; DONE load_data 0xDEADBEEF.
- LB addr 0x203, rdata 0x80000000 -> be 1000, load_data 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202 -> 0x00008000.
- SB addr 0x101, store_data 0x123456AB -> dmem_we 1, be 0010, dmem_addr 0x100, wdata 0xABABABAB. SH addr 0x102 -> be 1100.
- LW addr 0x102, then LH addr 0x101, then funct3=011 load -> no dmem_req; access_fault pulses with cause 0, 0, 1 respectively; stall 0.
- Ready withheld with TIMEOUT_CYCLES=16 -> dmem_req high 16 cycles, then drops; access_fault=1 cause 2; FSM back in IDLE.
- rst_n low during BUSY -> next cycle dmem_req=0, stall=0, all outputs 0; a new LW after reset completes normally.
